// File: rtl/mmio_bus_router_if.sv
// CPU-side and slave-side signal bundle of the MMIO bus router.
// The router connects through the slave modport (it serves the CPU request).
// The environment, i.e. the CPU plus the slave devices, uses the master modport.
interface mmio_bus_router_if #(
  parameter int N_SLAVES = 4,
  parameter int AW       = 27,
  parameter int DW       = 32
);
  // CPU request side
  logic [AW-1:0]          address;
  logic [DW-1:0]          data;
  logic                   we;
  logic                   start;
  logic                   busy;
  logic [DW-1:0]          q;
  logic                   err;
  // Slave side
  logic [N_SLAVES-1:0]    s_start;
  logic [N_SLAVES-1:0]    s_sel;
  logic [AW-1:0]          s_addr;
  logic [DW-1:0]          s_d;
  logic                   s_we;
  logic [N_SLAVES-1:0]    s_ack;
  logic [N_SLAVES*DW-1:0] s_q;

  modport slave (
    input  address, data, we, start, s_ack, s_q,
    output busy, q, err, s_start, s_sel, s_addr, s_d, s_we
  );

  modport master (
    output address, data, we, start, s_ack, s_q,
    input  busy, q, err, s_start, s_sel, s_addr, s_d, s_we
  );
endinterface

// File: rtl/mmio_bus_router.sv
// Memory-mapped bus router.
// It decodes a CPU start/busy request against a table of address windows.
// The request goes to exactly one slave through a start/ack handshake.
// The read data, or an error flag, returns to the CPU.
// A per-transaction timeout frees the CPU when a slave never acknowledges.
// All state changes on the falling edge of clk.
module mmio_bus_router #(
  parameter int                      N_SLAVES = 4,
  parameter int                      AW       = 27,
  parameter int                      DW       = 32,
  parameter logic [N_SLAVES*AW-1:0]  BASES    = {27'hC02622, 27'hC00420, 27'hC00000, 27'h0},
  parameter logic [N_SLAVES*AW-1:0]  LIMITS   = {27'hC02735, 27'hC02422, 27'hC00420, 27'h800000},
  parameter int                      TIMEOUT  = 1023,
  parameter int                      TW       = 10
) (
  input  logic               clk,
  input  logic               reset,
  mmio_bus_router_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT);

  state_t              r_state;
  state_t              w_next;

  logic                r_busy;
  logic [DW-1:0]       r_q;
  logic                r_err;
  logic [N_SLAVES-1:0] r_sel;
  logic [AW-1:0]       r_addr;
  logic [DW-1:0]       r_d;
  logic                r_we;
  logic [TW-1:0]       r_cnt;

  logic                w_match;
  logic [N_SLAVES-1:0] w_dec_sel;
  logic [AW-1:0]       w_dec_base;
  logic [AW-1:0]       w_off;
  logic                w_ack;
  logic [DW-1:0]       w_rdata;
  logic                w_tmo;

  // Window decode; scanning downward lets the lowest matching index win on overlap
  always_comb begin
    w_match    = 1'b0;
    w_dec_sel  = '0;
    w_dec_base = '0;
    for (int i = N_SLAVES-1; i >= 0; i--) begin
      if ((bus.address >= BASES[i*AW +: AW]) && (bus.address < LIMITS[i*AW +: AW])) begin
        w_match    = 1'b1;
        w_dec_sel  = N_SLAVES'(1) << i;
        w_dec_base = BASES[i*AW +: AW];
      end
    end
  end

  assign w_off = bus.address - w_dec_base;
  assign w_tmo = (r_cnt == TO_VAL);

  // Pick ack and read data of the selected slave only; others are ignored
  always_comb begin
    w_ack   = 1'b0;
    w_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (r_sel[i]) begin
        w_ack   = bus.s_ack[i];
        w_rdata = bus.s_q[i*DW +: DW];
      end
    end
  end

  // State register
  always_ff @(negedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; DONE waits for start to drop so a held start cannot re-trigger
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = w_match ? ISSUE : DONE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (w_ack || w_tmo) w_next = DONE;
      DONE:    if (!bus.start) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request capture, timeout counter and completion results
  always_ff @(negedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_q    <= '0;
      r_err  <= 1'b0;
      r_sel  <= '0;
      r_addr <= '0;
      r_d    <= '0;
      r_we   <= 1'b0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (w_match) begin
              r_busy <= 1'b1;
              r_sel  <= w_dec_sel;
              r_addr <= w_off;
              r_d    <= bus.data;
              r_we   <= bus.we;
            end else begin
              // Unmapped: complete at once with an error, never touch a slave
              r_busy <= 1'b0;
              r_q    <= '0;
              r_err  <= 1'b1;
            end
          end
        end
        ISSUE: r_cnt <= '0;
        WAIT: begin
          // Ack is tested first so it wins over a timeout on the same edge
          if (w_ack) begin
            r_q    <= w_rdata;
            r_err  <= 1'b0;
            r_busy <= 1'b0;
            r_sel  <= '0;
          end else if (w_tmo) begin
            r_q    <= '0;
            r_err  <= 1'b1;
            r_busy <= 1'b0;
            r_sel  <= '0;
          end else begin
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs; the slave start pulse is exactly the single ISSUE cycle
  always_comb begin
    bus.s_start = (r_state == ISSUE) ? r_sel : '0;
    bus.busy    = r_busy;
    bus.q       = r_q;
    bus.err     = r_err;
    bus.s_sel   = r_sel;
    bus.s_addr  = r_addr;
    bus.s_d     = r_d;
    bus.s_we    = r_we;
  end

endmodule
